// File: rtl/cic_iq_pkg.sv
// Shared types and constants for the CIC I/Q output scheduler.
package cic_iq_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SEND_I = 2'd2,
        ST_SEND_Q = 2'd3
    } iq_state_e;

    localparam logic IQ_I = 1'b0;
    localparam logic IQ_Q = 1'b1;

    localparam logic signed [15:0] SAT_MAX16 = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN16 = 16'sh8000;

endpackage

// File: rtl/cic_iq_sched_sat_shift.sv
// Signed arithmetic shift-left with saturation to SW bits.
// Only built when CIC_IQ_GAIN_EN is defined.
`ifdef CIC_IQ_GAIN_EN
module cic_sat_shift #(
    parameter int unsigned SW        = 16,
    parameter int unsigned GAIN_BITS = 3
) (
    input  logic [SW-1:0]        data_i,
    input  logic [GAIN_BITS-1:0] shift_i,
    output logic [SW-1:0]        data_o
);

    localparam int unsigned EW = SW + (1 << GAIN_BITS);
    localparam logic signed [EW-1:0] MAX_EXT = {{(EW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_EXT = {{(EW-SW+1){1'b1}}, {(SW-1){1'b0}}};

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shifted;

    always_comb begin
        ext     = {{(EW-SW){data_i[SW-1]}}, data_i};
        shifted = ext <<< shift_i;
        if (shifted > MAX_EXT) begin
            data_o = MAX_EXT[SW-1:0];
        end else if (shifted < MIN_EXT) begin
            data_o = MIN_EXT[SW-1:0];
        end else begin
            data_o = shifted[SW-1:0];
        end
    end

endmodule
`endif

// File: rtl/cic_iq_sched.sv
// Pairs I/Q CIC decimator outputs, discards settle pairs, emits I-then-Q words.
// Optional CIC_IQ_GAIN_EN adds a per-pair saturating left-shift gain.
module cic_iq_sched
    import cic_iq_pkg::*;
#(
    parameter int unsigned SETTLE_PAIRS = 4,
    parameter int unsigned SW           = 16,
    parameter int unsigned GAIN_BITS    = 3
) (
    input  logic          CLK,
    input  logic          RSTb,
    input  logic          restart,
    input  logic          i_tick,
    input  logic [SW-1:0] i_data,
    input  logic          q_tick,
    input  logic [SW-1:0] q_data,
    output logic [SW-1:0] out_data,
    output logic          out_iq,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          settled,
    output logic          overrun,
    input  logic          clr_overrun
`ifdef CIC_IQ_GAIN_EN
    ,
    input  logic [GAIN_BITS-1:0] gain
`endif
);

    localparam iq_state_e  INIT_STATE   = (SETTLE_PAIRS == 0) ? ST_IDLE : ST_SETTLE;
    localparam logic       INIT_SETTLED = (SETTLE_PAIRS == 0);
    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_PAIRS - 1);

    iq_state_e     state_q, state_d;
    logic [SW-1:0] i_hold_q, i_hold_d, q_hold_q, q_hold_d;
    logic          i_full_q, i_full_d, q_full_q, q_full_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [SW-1:0] out_data_q, out_data_d;
    logic          out_iq_q, out_iq_d, out_valid_q, out_valid_d;
    logic          settled_q, settled_d, overrun_q, overrun_d;

    logic          pair, hs, i_clr, q_clr, load_i, load_q;
    logic          i_acc, q_acc, i_drop, q_drop;
    logic [SW-1:0] word_src, word_out;

`ifdef CIC_IQ_GAIN_EN
    logic [GAIN_BITS-1:0] gain_q, gain_d, shift_sel;

    // The I word shifts by live gain (sampled on entry to SEND_I); Q reuses it.
    assign shift_sel = load_q ? gain_q : gain;
    assign gain_d    = load_i ? gain : gain_q;

    cic_sat_shift #(.SW(SW), .GAIN_BITS(GAIN_BITS)) u_sat_shift (
        .data_i (word_src),
        .shift_i(shift_sel),
        .data_o (word_out)
    );
`else
    assign word_out = word_src;
`endif

    assign word_src = load_q ? q_hold_q : i_hold_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        settled_d   = settled_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_iq_d    = out_iq_q;
        i_clr       = 1'b0;
        q_clr       = 1'b0;
        load_i      = 1'b0;
        load_q      = 1'b0;
        pair        = i_full_q & q_full_q;
        hs          = out_valid_q & out_ready;

        case (state_q)
            ST_SETTLE: if (pair) begin
                i_clr = 1'b1;
                q_clr = 1'b1;
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d   = ST_IDLE;
                    settled_d = 1'b1;
                end
            end
            ST_IDLE: if (pair) begin
                state_d     = ST_SEND_I;
                out_valid_d = 1'b1;
                load_i      = 1'b1;
            end
            ST_SEND_I: if (hs) begin
                state_d = ST_SEND_Q;
                load_q  = 1'b1;
                i_clr   = 1'b1;
            end
            ST_SEND_Q: if (hs) begin
                q_clr = 1'b1;
                // Next pair's Q lands in q_hold this same edge, so no bubble.
                if (i_full_q && q_tick) begin
                    state_d = ST_SEND_I;
                    load_i  = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = INIT_STATE;
        endcase

        if (load_i) begin
            out_data_d = word_out;
            out_iq_d   = IQ_I;
        end
        if (load_q) begin
            out_data_d = word_out;
            out_iq_d   = IQ_Q;
        end

        i_acc    = i_tick & (~i_full_q | i_clr);
        q_acc    = q_tick & (~q_full_q | q_clr);
        i_drop   = i_tick & i_full_q & ~i_clr;
        q_drop   = q_tick & q_full_q & ~q_clr;
        i_full_d = i_acc | (i_full_q & ~i_clr);
        q_full_d = q_acc | (q_full_q & ~q_clr);
        i_hold_d = i_acc ? i_data : i_hold_q;
        q_hold_d = q_acc ? q_data : q_hold_q;
        overrun_d = (i_drop | q_drop) | (overrun_q & ~clr_overrun);

        if (restart) begin
            state_d     = INIT_STATE;
            i_full_d    = 1'b0;
            q_full_d    = 1'b0;
            i_hold_d    = i_hold_q;
            q_hold_d    = q_hold_q;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            settled_d   = INIT_SETTLED;
            overrun_d   = overrun_q & ~clr_overrun;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q     <= INIT_STATE;
            i_hold_q    <= '0;
            q_hold_q    <= '0;
            i_full_q    <= 1'b0;
            q_full_q    <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_iq_q    <= IQ_I;
            out_valid_q <= 1'b0;
            settled_q   <= INIT_SETTLED;
            overrun_q   <= 1'b0;
`ifdef CIC_IQ_GAIN_EN
            gain_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            i_hold_q    <= i_hold_d;
            q_hold_q    <= q_hold_d;
            i_full_q    <= i_full_d;
            q_full_q    <= q_full_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_iq_q    <= out_iq_d;
            out_valid_q <= out_valid_d;
            settled_q   <= settled_d;
            overrun_q   <= overrun_d;
`ifdef CIC_IQ_GAIN_EN
            if (!restart) gain_q <= gain_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_iq    = out_iq_q;
    assign out_valid = out_valid_q;
    assign settled   = settled_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_iq_sched.sv
// Directed self-checking bench for cic_iq_sched (SETTLE_PAIRS=4, SW=16).
module tb_cic_iq_sched;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic        restart = 1'b0;
    logic        i_tick = 1'b0;
    logic [15:0] i_data = '0;
    logic        q_tick = 1'b0;
    logic [15:0] q_data = '0;
    logic [15:0] out_data;
    logic        out_iq;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        settled;
    logic        overrun;
    logic        clr_overrun = 1'b0;
`ifdef CIC_IQ_GAIN_EN
    logic [2:0]  gain = 3'd3;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int vcount = 0;

    cic_iq_sched #(.SETTLE_PAIRS(4), .SW(16), .GAIN_BITS(3)) dut (
        .CLK        (CLK),
        .RSTb       (RSTb),
        .restart    (restart),
        .i_tick     (i_tick),
        .i_data     (i_data),
        .q_tick     (q_tick),
        .q_data     (q_data),
        .out_data   (out_data),
        .out_iq     (out_iq),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .settled    (settled),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
`ifdef CIC_IQ_GAIN_EN
        ,
        .gain       (gain)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
        if (out_valid) vcount++;
    endtask

    // I tick, then Q tick three cycles later; both flags set after return.
    task automatic send_pair(input logic [15:0] id, input logic [15:0] qd);
        i_tick = 1'b1; i_data = id;
        step();
        i_tick = 1'b0;
        step();
        step();
        q_tick = 1'b1; q_data = qd;
        step();
        q_tick = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_iq", 32'(out_iq), 32'd0);
        check("rst_settled", 32'(settled), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        step();
        step();
        RSTb = 1'b1;

        // Settle: four pairs discarded, fifth emitted back-to-back
        out_ready = 1'b1;
        vcount = 0;
        for (int p = 0; p < 3; p++) begin
            send_pair(16'(p + 1), 16'(p + 16'h100));
            step();
        end
        check("settle_not_yet", 32'(settled), 32'd0);
        send_pair(16'h0004, 16'h0104);
        step();
        check("settle_done", 32'(settled), 32'd1);
        check("settle_no_valid", 32'(vcount), 32'd0);
        send_pair(16'h1111, 16'h2222);
        step();
        check("p5_i_valid", 32'(out_valid), 32'd1);
        check("p5_i_data", 32'(out_data), 32'h1111);
        check("p5_i_iq", 32'(out_iq), 32'd0);
        step();
        check("p5_q_data", 32'(out_data), 32'h2222);
        check("p5_q_iq", 32'(out_iq), 32'd1);
        step();
        check("p5_idle", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        send_pair(16'h1234, 16'hFEDC);
        step();
        begin
            int bad = 0;
            for (int k = 0; k < 10; k++) begin
                if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_iq !== 1'b0) bad++;
                step();
            end
            check("bp_stable_bad_cycles", 32'(bad), 32'd0);
        end
        check("bp_i_data", 32'(out_data), 32'h1234);
        out_ready = 1'b1;
        step();
        check("bp_q_data", 32'(out_data), 32'hFEDC);
        check("bp_q_iq", 32'(out_iq), 32'd1);
        step();
        check("bp_idle", 32'(out_valid), 32'd0);

        // Overrun
        out_ready = 1'b0;
        i_tick = 1'b1; i_data = 16'h7000;
        step();
        i_data = 16'h0001;
        step();
        i_tick = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        q_tick = 1'b1; q_data = 16'h0ABC;
        step();
        q_tick = 1'b0;
        step();
        check("ovr_i_kept", 32'(out_data), 32'h7000);
        out_ready = 1'b1;
        step();
        check("ovr_q_data", 32'(out_data), 32'h0ABC);
        step();
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        i_tick = 1'b1; i_data = 16'h0005;
        step();
        i_data = 16'h0006; clr_overrun = 1'b1;
        step();
        i_tick = 1'b0; clr_overrun = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'd1);
        q_tick = 1'b1; q_data = 16'h0007;
        step();
        q_tick = 1'b0;
        step();
        check("ovr2_i_kept", 32'(out_data), 32'h0005);
        step();
        step();
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("ovr_clr2", 32'(overrun), 32'd0);

        // Back-to-back pairs with no bubble
        out_ready = 1'b0;
        i_tick = 1'b1; i_data = 16'h00A1;
        q_tick = 1'b1; q_data = 16'h00B1;
        step();
        i_tick = 1'b0; q_tick = 1'b0;
        step();
        check("b2b_a", 32'(out_data), 32'h00A1);
        out_ready = 1'b1;
        step();
        check("b2b_b", 32'(out_data), 32'h00B1);
        out_ready = 1'b0;
        i_tick = 1'b1; i_data = 16'h00C1;
        step();
        i_tick = 1'b0;
        out_ready = 1'b1;
        q_tick = 1'b1; q_data = 16'h00D1;
        step();
        q_tick = 1'b0;
        check("b2b_c_valid", 32'(out_valid), 32'd1);
        check("b2b_c_data", 32'(out_data), 32'h00C1);
        check("b2b_c_iq", 32'(out_iq), 32'd0);
        step();
        check("b2b_d_data", 32'(out_data), 32'h00D1);
        step();
        check("b2b_idle", 32'(out_valid), 32'd0);
        check("b2b_no_ovr", 32'(overrun), 32'd0);

        // Restart during SEND_Q with ready low
        out_ready = 1'b0;
        i_tick = 1'b1; i_data = 16'h0AAA;
        step();
        i_data = 16'h0ACC;
        step();
        i_tick = 1'b0;
        q_tick = 1'b1; q_data = 16'h0DDD;
        step();
        q_tick = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check("rs_in_send_q", 32'(out_iq), 32'd1);
        restart = 1'b1; i_tick = 1'b1; i_data = 16'h0BBB;
        step();
        restart = 1'b0; i_tick = 1'b0;
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_settled", 32'(settled), 32'd0);
        check("rs_overrun_kept", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        vcount = 0;
        out_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            send_pair(16'(p + 16'h10), 16'(p + 16'h20));
            step();
        end
        check("rs_resettled", 32'(settled), 32'd1);
        check("rs_no_valid", 32'(vcount), 32'd0);
        check("rs_tick_ignored", 32'(overrun), 32'd0);

        // Asynchronous reset mid SEND_I
        out_ready = 1'b0;
        send_pair(16'h0321, 16'h0654);
        step();
        check("ar_pre_data", 32'(out_data), 32'h0321);
        #2;
        RSTb = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        check("ar_settled", 32'(settled), 32'd0);
        step();
        RSTb = 1'b1;
        vcount = 0;
        out_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            send_pair(16'(p + 16'h30), 16'(p + 16'h40));
            step();
        end
        check("ar_resettled", 32'(settled), 32'd1);
        check("ar_no_valid", 32'(vcount), 32'd0);
        send_pair(16'h0777, 16'h0888);
        step();
        check("ar_emit", 32'(out_data), 32'h0777);
        step();
        step();

`ifdef CIC_IQ_GAIN_EN
        send_pair(16'h0100, 16'hC000);
        step();
        check("gain_i", 32'(out_data), 32'h0800);
        step();
        check("gain_q_sat", 32'(out_data), 32'h8000);
        step();
        send_pair(16'h2000, 16'h0000);
        step();
        check("gain_i_sat", 32'(out_data), 32'h7FFF);
        step();
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cic_iq_sched.md
Name: cic_iq_sched

Overview:
- Output scheduler for a pair of CIC decimators (I and Q), one instance per mixer arm.
- Captures each decimator's 16-bit output on its out_tick and pairs I with Q samples.
- Discards the first SETTLE_PAIRS pairs after reset or restart, while the comb section fills.
- Emits interleaved I-then-Q words on a valid/ready stream to the downstream serialiser, and flags lost samples.

Parameters:
- SETTLE_PAIRS, 4: number of complete I/Q pairs discarded after reset/restart (0..255; 0 = no discard).
- SW, 16: sample width; matches the CIC x_out width.
- GAIN_BITS, 3: width of gain shift control (used only with optional feature).

Ports:
- CLK  in  1  system clock
- RSTb  in  1  asynchronous active-low reset
- restart  in  1  synchronous pulse: flush and re-enter settle
- i_tick  in  1  I decimator out_tick (1-cycle strobe)
- i_data  in  SW  I decimator x_out, signed
- q_tick  in  1  Q decimator out_tick
- q_data  in  SW  Q decimator x_out, signed
- out_data  out  SW  stream word, signed
- out_iq  out  1  0 = I word, 1 = Q word
- out_valid  out  1  out_data/out_iq valid
- out_ready  in  1  downstream accepts when high with out_valid
- settled  out  1  high once the settle phase is complete
- overrun  out  1  sticky: a sample was dropped
- clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- One clock, CLK; RSTb is asynchronous and active-low. All state clears on RSTb low.
- Reset values: out_data=0, out_iq=0, out_valid=0, settled=0 (1 if SETTLE_PAIRS=0), overrun=0, hold flags=0, settle count=0.
- Capture: i_hold/i_full and q_hold/q_full. A tick with its full flag at 0 loads the hold register and sets the flag.
- Drop rule: a tick with its full flag at 1 that is not cleared in the same cycle drops the sample and sets overrun.
- Tick coincident with a flag clear: the sample is accepted and the flag stays 1.
- A pair is complete when i_full and q_full are both 1.
- FSM states: SETTLE, IDLE, SEND_I, SEND_Q.
  - Post-reset state is SETTLE, or IDLE if SETTLE_PAIRS=0.
- SETTLE, on pair complete:
  - Clear both flags and increment the count.
  - If the count was SETTLE_PAIRS-1: go to IDLE and set settled.
  - out_valid stays 0 throughout SETTLE.
- IDLE, on pair complete: go to SEND_I and assert out_valid.
  - out_data=i_hold, out_iq=0, registered.
  - Latency: flags both set in cycle N → out_valid high in cycle N+1.
- SEND_I, on out_valid&out_ready:
  - Next cycle out_data=q_hold, out_iq=1; go to SEND_Q.
  - Clear i_full so the next I sample can be captured.
- SEND_Q, on out_valid&out_ready:
  - Clear q_full.
  - If i_full=1 and a Q sample is arriving or already held for the next pair, go directly to SEND_I with no bubble; else go to IDLE and drop out_valid.
- Stability: while out_valid=1 and out_ready=0, out_data and out_iq hold stable (AXI-style).
- restart (any state):
  - Next cycle: state=SETTLE (or IDLE if SETTLE_PAIRS=0), flags=0, count=0, out_valid=0, settled=0 (1 if SETTLE_PAIRS=0).
  - Ticks in the restart cycle are ignored.
  - overrun is preserved.
  - restart has priority over the handshake.
- clr_overrun coincident with a drop: overrun stays 1 (set wins).
- Settle counter is 8 bits and saturates; it never wraps.

Optional Feature:
- Macro: CIC_IQ_GAIN_EN.
- Defined:
  - Adds input port gain [GAIN_BITS-1:0].
  - Each word is shifted left arithmetically by gain, then saturated to SW-bit signed (+32767 / -32768).
  - Gain is sampled when entering SEND_I and held for both words of the pair.
  - Shift/saturate is combinational ahead of the out_data register, so latency is unchanged.
- Undefined: no gain port; words pass through unmodified.

Decomposition:
- Package cic_iq_pkg:
  - FSM state localparams (2-bit encoding: SETTLE=0, IDLE=1, SEND_I=2, SEND_Q=3).
  - IQ tag constants (IQ_I=0, IQ_Q=1).
  - Saturation limit constants.
- Sub-module: cic_sat_shift (signed shift-left with saturation), instantiated only under CIC_IQ_GAIN_EN.

Test Plan:
- Settle: SETTLE_PAIRS=4, five I/Q pairs with Q tick 3 cycles after I, out_ready=1 → first four pairs produce no out_valid; settled rises after the 4th; 5th pair emits I then Q on consecutive cycles.
- Backpressure: I=0x1234, Q=0xFEDC, out_ready low 10 cycles → out_valid held, out_data=0x1234, out_iq=0, stable; ready high → 0x1234 then 0xFEDC.
- Overrun: second i_tick (0x0001) before Q arrives, held I=0x7000 → overrun=1; emitted I stays 0x7000; clr_overrun clears it; coincident drop+clr keeps overrun=1.
- Restart mid-pair: restart while in SEND_Q with out_ready=0 → next cycle out_valid=0, settled=0, state SETTLE; overrun unchanged; 4 more pairs discarded.
- Async reset: RSTb low mid-SEND_I → outputs zero immediately without a clock edge; after release, settle restarts.
- Gain (CIC_IQ_GAIN_EN): gain=3, I=0x0100 → 0x0800; I=0x2000 → 0x7FFF; Q=0xC000 → 0x8000.
